// File: rtl/cordic_phase_diff.sv
// Phase-difference back-end of the CORDIC FM chain: turns atan2 done levels into
// angle events, wraps successive differences and sums DECIM of them per output word.
module cordic_phase_diff #(
    parameter int WIDTH     = 32,
    parameter int DECIM     = 4,
    parameter int ACC_WIDTH = WIDTH + $clog2(DECIM) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_done,
    input  logic signed [WIDTH-1:0]     in_angle,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_freq,
    output logic                        overrun
);
    localparam int            CW   = $clog2(DECIM + 1);
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    typedef enum logic {EMPTY, RUN} state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       done_q;
    logic                       ev;
    logic                       complete;
    logic signed [WIDTH-1:0]    prev;
    logic signed [WIDTH-1:0]    d;
    logic signed [ACC_WIDTH-1:0] d_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [CW-1:0]              count;

    assign ev       = in_done & ~done_q;
    // Truncating to WIDTH bits gives the shortest-arc difference; exactly pi stays negative.
    assign d        = in_angle - prev;
    assign d_ext    = {{(ACC_WIDTH-WIDTH){d[WIDTH-1]}}, d};
    assign sum      = acc + d_ext;
    assign complete = ev && (state == RUN) && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = EMPTY;
        end else if (ev) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q    <= 1'b1;
            prev      <= '0;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_freq  <= '0;
            overrun   <= 1'b0;
        end else begin
            done_q <= in_done;
            if (clear) begin
                acc       <= '0;
                count     <= '0;
                out_valid <= 1'b0;
                out_freq  <= '0;
                overrun   <= 1'b0;
            end else begin
                if (ev) begin
                    prev <= in_angle;
                    if (state == RUN) begin
                        if (count == LAST) begin
                            acc   <= '0;
                            count <= '0;
                        end else begin
                            acc   <= sum;
                            count <= count + CW'(1);
                        end
                    end
                end
                // A result that completes while the slot is held is dropped, not queued.
                if (complete) begin
                    if (out_valid && !out_ready) begin
                        overrun <= 1'b1;
                    end else begin
                        out_freq  <= sum;
                        out_valid <= 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_phase_diff.sv
// Directed bench for cordic_phase_diff: a reference model pushes expected frequency
// words into a queue as angle events are driven; results are popped as the DUT offers them.
module tb_cordic_phase_diff;
    localparam int WIDTH     = 32;
    localparam int DECIM     = 4;
    localparam int ACC_WIDTH = WIDTH + $clog2(DECIM) + 1;

    logic                        clk;
    logic                        reset;
    logic                        clear;
    logic                        in_done;
    logic signed [WIDTH-1:0]     in_angle;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_freq;
    logic                        overrun;

    int     checkCount = 0;
    int     passCount  = 0;
    int     failCount  = 0;
    longint expQ[$];
    logic [31:0] mPrev;
    longint mAcc;
    int     mCount;
    bit     mPrimed;
    bit     mSlotFull;
    bit     mOverrun;

    cordic_phase_diff #(.WIDTH(WIDTH), .DECIM(DECIM), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_done(in_done), .in_angle(in_angle),
        .out_valid(out_valid), .out_ready(out_ready), .out_freq(out_freq), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset;
        expQ.delete();
        mAcc      = 0;
        mCount    = 0;
        mPrimed   = 0;
        mSlotFull = 0;
        mOverrun  = 0;
        mPrev     = '0;
    endtask

    // Independent model of one angle event: shortest-arc difference in 32-bit arithmetic.
    task automatic modelEvent(input logic [31:0] a);
        logic [31:0] diff;
        int          dS;
        if (!mPrimed) begin
            mPrimed = 1;
        end else begin
            diff   = a - mPrev;
            dS     = int'(diff);
            mAcc  += longint'(dS);
            mCount++;
            if (mCount == DECIM) begin
                if (mSlotFull && out_ready !== 1'b1) begin
                    mOverrun = 1;
                end else begin
                    expQ.push_back(mAcc);
                    mSlotFull = 1;
                end
                mAcc   = 0;
                mCount = 0;
            end
        end
        mPrev = a;
    endtask

    task automatic pulseAngle(input logic [31:0] a, input int high);
        in_angle = a;
        in_done  = 1'b1;
        modelEvent(a);
        for (int i = 0; i < high; i++) begin
            tick;
            if (i == 0) in_angle = $urandom;
        end
        in_done  = 1'b0;
        in_angle = $urandom;
        tick;
    endtask

    task automatic takeResult(input string tag);
        int waitCycles = 0;
        logic signed [63:0] expVal;
        while (out_valid !== 1'b1 && waitCycles < 8) begin
            tick;
            waitCycles++;
        end
        checkVal({tag, "_valid"}, out_valid, 1);
        expVal = (expQ.size() > 0) ? expQ.pop_front() : 64'sbx;
        checkVal({tag, "_freq"}, out_freq, expVal);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        mSlotFull = 0;
        checkVal({tag, "_drained"}, out_valid, 0);
    endtask

    task automatic clearBlock(input string tag);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        modelReset();
        checkVal({tag, "_valid"}, out_valid, 0);
        checkVal({tag, "_overrun"}, overrun, 0);
        checkVal({tag, "_freq"}, out_freq, 0);
    endtask

    // Called at edge+1: asserts reset between edges and checks outputs before the next edge.
    task automatic asyncReset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        checkVal({tag, "_valid"}, out_valid, 0);
        checkVal({tag, "_freq"}, out_freq, 0);
        checkVal({tag, "_overrun"}, overrun, 0);
        #3;
        reset = 1'b1;
        modelReset();
        tick;
        tick;
    endtask

    task automatic applyStimulus;
        logic [31:0] a;

        // reset state
        tick;
        asyncReset("reset");

        // priming and step, with exact output latency
        for (int k = 0; k < 4; k++) begin
            pulseAngle(32'(k) * 32'h1000_0000, 1);
            checkVal("step_novalid", out_valid, 0);
        end
        in_angle = 32'h4000_0000;
        in_done  = 1'b1;
        modelEvent(32'h4000_0000);
        checkVal("step_prelaunch", out_valid, 0);
        tick;
        in_done = 1'b0;
        checkVal("step_latency", out_valid, 1);
        tick;
        takeResult("step");

        // wrap across +/-pi
        clearBlock("clr_wrap");
        for (int k = 0; k < 5; k++) pulseAngle(32'h6000_0000 + 32'(k) * 32'h2000_0000, 1);
        takeResult("wrap");

        // level-held done counts once per rising edge
        clearBlock("clr_level");
        for (int k = 0; k < 5; k++) begin
            pulseAngle(32'(k) * 32'h1000_0000, 6);
            if (k == 3) checkVal("level_novalid", out_valid, 0);
        end
        takeResult("level");
        repeat (3) tick;
        checkVal("level_single", out_valid, 0);

        // done high across reset release is ignored
        in_done = 1'b1;
        asyncReset("rst_done_high");
        in_done = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            pulseAngle(32'(k) * 32'h1000_0000, 1);
            if (k == 3) checkVal("rstlvl_novalid", out_valid, 0);
        end
        takeResult("rstlvl");

        // backpressure and overrun
        clearBlock("clr_bp");
        for (int k = 0; k < 5; k++) pulseAngle(32'(k) * 32'h1000_0000, 1);
        for (int k = 1; k < 5; k++) pulseAngle(32'h4000_0000 + 32'(k) * 32'h0800_0000, 1);
        checkVal("bp_valid", out_valid, 1);
        checkVal("bp_held", out_freq, expQ[0]);
        checkVal("bp_overrun", overrun, mOverrun);
        takeResult("bp");
        checkVal("bp_sticky", overrun, 1);

        // clear mid-accumulation restarts priming
        pulseAngle(32'h5000_0000, 1);
        pulseAngle(32'h5100_0000, 1);
        clearBlock("clr_mid");
        for (int k = 0; k < 5; k++) begin
            pulseAngle(32'h1234_5678 + 32'(k) * 32'h0100_0000, 1);
            if (k == 3) checkVal("clrmid_novalid", out_valid, 0);
        end
        takeResult("clrmid");

        // completion in the same cycle as a handshake
        clearBlock("clr_same");
        for (int k = 0; k < 5; k++) pulseAngle(32'(k) * 32'h1000_0000, 1);
        for (int k = 1; k < 4; k++) pulseAngle(32'h4000_0000 + 32'(k) * 32'h0400_0000, 1);
        a         = 32'h5000_0000;
        in_angle  = a;
        in_done   = 1'b1;
        out_ready = 1'b1;
        checkVal("same_old", out_freq, expQ.pop_front());
        mSlotFull = 0;
        modelEvent(a);
        tick;
        out_ready = 1'b0;
        in_done   = 1'b0;
        checkVal("same_valid", out_valid, 1);
        checkVal("same_overrun", overrun, 0);
        tick;
        takeResult("same");

        // exactly-pi differences stay negative, then reset with a result pending
        clearBlock("clr_pi");
        for (int k = 0; k < 5; k++) pulseAngle((k % 2 == 1) ? 32'h8000_0000 : 32'h0, 1);
        checkVal("pi_valid", out_valid, 1);
        checkVal("pi_freq", out_freq, expQ[0]);
        asyncReset("midreset");
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_done   = 1'b0;
        in_angle  = '0;
        out_ready = 1'b0;
        modelReset();
        applyStimulus();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cordic_phase_diff.md
Name: cordic_phase_diff

Overview:
Downstream consumer of the CORDIC atan2 stage: takes each completed binary angle (full scale 2^WIDTH = 2*pi), computes the wrapped phase difference from the previous angle, and sums DECIM consecutive differences into one decimated frequency word. It converts the atan2 stage's level-held done into sample events. It presents results on a valid/ready output with an overrun flag. This forms the discriminator back-end of the CORDIC FM/phase-tracking chain.

Parameters:
WIDTH, 32, bit width of the input angle (matches atan2 angle width)
DECIM, 4, number of phase differences summed per output word (>=1)
ACC_WIDTH, WIDTH+$clog2(DECIM)+1, signed width of accumulator and output

Ports:
clk  input  1  system clock; one clock domain, all logic rising-edge
reset  input  1  reset is asynchronous and active-low
clear  input  1  synchronous flush of history, accumulator, output and overrun
in_done  input  1  done level from atan2 stage; rising edge marks a new angle
in_angle  input  WIDTH  signed binary angle, valid in the cycle in_done rises
out_valid  output  1  out_freq holds an unconsumed result
out_ready  input  1  downstream accepts out_freq when high with out_valid
out_freq  output  ACC_WIDTH  signed sum of DECIM wrapped phase differences
overrun  output  1  sticky: a completed result was dropped

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_freq=0, overrun=0, acc=0, count=0, state=EMPTY, done_q=1. done_q resets to 1 so that a done level already high at reset release is not counted.
- Event: ev = in_done & ~done_q. done_q <= in_done every cycle. A done level held N cycles yields exactly one event. in_angle is sampled only in the ev cycle.
- State EMPTY: on ev, set prev <= in_angle, move to RUN. No difference is produced.
- State RUN: on ev, d = in_angle - prev, truncated to WIDTH bits and taken as signed. Natural wrap gives d in [-2^(WIDTH-1), 2^(WIDTH-1)-1], i.e. the shortest-arc difference. d = -2^(WIDTH-1) (exactly pi) is kept as negative.
  - Then prev <= in_angle.
  - acc <= acc + sign_ext(d), count <= count+1.
- Completion: when the ev brings count to DECIM, the result is R = acc + d.
  - acc <= 0 and count <= 0 in that same cycle.
  - R is offered to the output slot on the next clock edge, so out_valid rises the cycle after the completing ev.
- Output slot:
  - Held stable while out_valid & ~out_ready.
  - Handshake when out_valid & out_ready: the slot is freed at that edge.
  - Completion with the slot free, or freed by a handshake in the same cycle: load R, out_valid=1, no overrun.
  - Completion with out_valid & ~out_ready: R is discarded, the old result is kept, overrun <= 1.
  - overrun clears only on reset or clear.
- Back-to-back events on consecutive cycles are accepted. The block never stalls its input; there is no input ready.
- clear takes priority over ev and handshake. It sets state=EMPTY, acc=0, count=0, out_valid=0, overrun=0, and loads done_q from in_done, so a level that is high does not count.
- Async reset mid-accumulation forces all state to reset values immediately. Outputs go to 0 without waiting for a clock edge.
- ACC_WIDTH guarantees no overflow: |R| <= DECIM*2^(WIDTH-1).

Test Plan:
- Priming and step: WIDTH=32, DECIM=4; angles 0, 2^28, 2^29, 3*2^28, 2^30, each as a done pulse. Required: no out_valid after the first four; out_valid one cycle after the fifth ev with out_freq = 1073741824.
- Wrap across ±pi: angles 0x60000000, 0x80000000, 0xA0000000, 0xC0000000, 0xE0000000. Required: out_freq = +2147483648; no negative wrap artefact.
- Level done: in_done held high 6 cycles, then low, repeated 5 times with the same angles as the step test. Required: exactly one result, 1073741824. Separately, in_done high during reset release is ignored, so 5 more edges are needed for a result.
- Backpressure/overrun: out_ready=0, complete two results (steps 2^28, then 2^27). Required: out_freq stays 1073741824, overrun=1. With out_ready=1, one handshake occurs, then out_valid=0. A completion in the same cycle as a handshake loads with no overrun.
- Clear and reset mid-op: after 2 differences assert clear. Required: out_valid=0, overrun=0, and the next ev is treated as first. Async reset asserted mid-cycle with out_valid=1: out_valid drops to 0 before the next clk edge.
